layer_compositor: RTL and testbench
===================================

Name: layer_compositor

Overview:
- Parametrised multi-layer pixel compositor for the VGA path.
- Per scan pixel (posX, posY):
  - tests NUM_LAYERS run-time-positioned sprite rectangles plus a full-screen background;
  - issues per-layer ROM addresses;
  - picks the highest-priority non-transparent colour;
  - applies a game-state scene mode.
- Sits between the VGA timing generator and the display colour register; replaces fixed-position overlay logic.

Parameters:
- NUM_LAYERS, 4, number of sprite layers; layer 0 has highest priority.
- AW, 12, sprite ROM address width per layer.
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- KEY_COLOR, 16'hFFFF, RGB565 transparency key.
- INIT_COLOR, 16'hF0FF, fill colour in GAME_INITIAL.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- pix_valid  in  1  posX/posY valid this cycle
- posX  in  10  scan x, 0..SCR_W-1
- posY  in  9  scan y, 0..SCR_H-1
- game_state  in  2  00 INITIAL, 01 RUNNING, 10 OVER, 11 SUCCESS
- layer_en  in  NUM_LAYERS  per-layer enable mask
- cfg_we  in  1  layer config write strobe
- cfg_sel  in  clog2(NUM_LAYERS)  layer index to write
- cfg_x  in  10  layer origin x
- cfg_y  in  9  layer origin y
- cfg_w  in  10  layer width; 0 disables the layer
- cfg_h  in  9  layer height
- rom_addr  out  NUM_LAYERS*AW  flattened sprite ROM addresses; layer i at [i*AW +: AW]
- rom_data  in  NUM_LAYERS*16  sprite ROM data, synchronous, 1-cycle read latency
- bg_addr  out  19  background ROM address
- bg_data  in  16  background ROM data, 1-cycle latency
- ocolor  out  16  composited RGB565 pixel
- ocolor_valid  out  1  ocolor valid

Behaviour:
- Reset (async, active-high):
  - all config registers cleared (x=y=w=h=0, so all layers disabled);
  - pipeline valid bits cleared;
  - ocolor=16'h0000, ocolor_valid=0.
  - Reset mid-frame discards in-flight pixels.
  - ocolor_valid is low on the first clk edge after deassertion and stays low until a pix_valid pixel has traversed all 3 stages.
- Config:
  - on cfg_we at a clk edge, registers of layer cfg_sel are updated.
  - The written values apply to pixels sampled at stage S1 on the following edge and later.
  - cfg_sel >= NUM_LAYERS: write ignored.
- S1 (edge 1): for each layer, compute in 11-bit signed arithmetic:
  - rx = posX - x, ry = posY - y;
  - hit = (rx>=0) & (rx<w) & (ry>=0) & (ry<h) & layer_en[i] & (w!=0);
  - rom_addr registered = ry*w + rx, truncated to AW bits;
  - bg_addr registered = posY*SCR_W + posX;
  - hit, game_state and valid are registered.
  - No unsigned wrap: a layer at x=600, w=52 is clipped at x=639 and never hits x=0..11.
- S2 (edge 2): ROM data returns; hit, valid and game_state are delayed one stage to align with it.
- S3 (edge 3): ocolor registered. Latency is exactly 3 clocks from pix_valid to ocolor_valid.
- Selection in S3:
  - INITIAL: INIT_COLOR for every pixel.
  - RUNNING: lowest-index layer with hit and data != KEY_COLOR; else bg_data; if bg_data == KEY_COLOR, output KEY_COLOR.
  - OVER: same selection as RUNNING, then dimmed to {r>>1, g>>1, b>>1} (RGB565 fields [15:11], [10:5], [4:0]). KEY_COLOR passes undimmed.
  - SUCCESS: same as RUNNING, except layer NUM_LAYERS-1 (reward layer) is forced to highest priority.
- Edge and boundary rules:
  - a layer covers x..x+w-1 inclusive; pixel x+w is outside.
  - Overlapping hits: lower index wins; a transparent pixel of a higher-priority layer falls through to the next layer.
  - game_state changing mid-frame affects only pixels sampled at S1 after the change; no pixel mixes modes.
- Pipeline runs continuously: pix_valid=0 bubbles propagate as ocolor_valid=0, and ocolor holds its last value.

Test Plan:
- Reset check: assert rst mid-stream, release, drive pix_valid=1 → ocolor=0000 and valid=0 until the 3rd edge after the first valid pixel.
- Single layer: layer 0 at (100,50), w=10, h=4, rom returns addr as data, RUNNING.
  - Pixel (109,53) → rom_addr0=39, ocolor=0x0027, 3 cycles later.
  - Pixel (110,53) → bg_data.
- Priority and transparency: layers 0 and 1 overlap at (200,200); layer0 data=FFFF, layer1 data=07E0 → 07E0.
  - Layer0 data=F800 → F800.
  - SUCCESS with layer 3 also hit (data=001F) → 001F.
- Clipping: layer 2 at x=600, w=52 → no hit at posX=0..11 on the same row; hit at posX=639.
- OVER dimming: selected colour FFDF → 7BEF; selected colour FFFF → FFFF.
- Config timing: cfg_we moves layer 0 in the same cycle a pixel is in S2 → that pixel uses the old origin; the next pixel entering S1 uses the new origin; layer_en[0]=0 → bg_data.

Source files
------------

// File: rtl/layer_compositor.sv
// layer_compositor: run-time positioned sprite layers over a background,
// composited through a 3-stage pixel pipeline with game-state scene modes.
module layer_compositor #(
  parameter int NUM_LAYERS = 4,
  parameter int AW = 12,
  parameter int SCR_W = 640,
  parameter int SCR_H = 480,
  parameter logic [15:0] KEY_COLOR = 16'hFFFF,
  parameter logic [15:0] INIT_COLOR = 16'hF0FF,
  localparam int SW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pix_valid,
  input  logic [9:0]               posX,
  input  logic [8:0]               posY,
  input  logic [1:0]               game_state,
  input  logic [NUM_LAYERS-1:0]    layer_en,
  input  logic                     cfg_we,
  input  logic [SW-1:0]            cfg_sel,
  input  logic [9:0]               cfg_x,
  input  logic [8:0]               cfg_y,
  input  logic [9:0]               cfg_w,
  input  logic [8:0]               cfg_h,
  output logic [NUM_LAYERS*AW-1:0] rom_addr,
  input  logic [NUM_LAYERS*16-1:0] rom_data,
  output logic [18:0]              bg_addr,
  input  logic [15:0]              bg_data,
  output logic [15:0]              ocolor,
  output logic                     ocolor_valid
);

  localparam logic [1:0] GS_INITIAL = 2'b00;
  localparam logic [1:0] GS_OVER    = 2'b10;
  localparam logic [1:0] GS_SUCCESS = 2'b11;

  logic [9:0] cx [NUM_LAYERS];
  logic [8:0] cy [NUM_LAYERS];
  logic [9:0] cw [NUM_LAYERS];
  logic [8:0] ch [NUM_LAYERS];

  logic signed [10:0] rx [NUM_LAYERS];
  logic signed [10:0] ry [NUM_LAYERS];
  logic [21:0]        prod [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] hit_c;
  logic [18:0]        bg_c;
  logic               on_scr;

  logic [NUM_LAYERS-1:0] hit1, hit2;
  logic [1:0]            gs1, gs2;
  logic                  v1, v2;

  logic [15:0] pick;
  logic [15:0] mix_c;

  // Layer geometry registers; out-of-range selects match no layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        cx[i] <= '0;
        cy[i] <= '0;
        cw[i] <= '0;
        ch[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_sel == SW'(i)) begin
          cx[i] <= cfg_x;
          cy[i] <= cfg_y;
          cw[i] <= cfg_w;
          ch[i] <= cfg_h;
        end
      end
    end
  end

  assign on_scr = (posX < 10'(SCR_W)) && (posY < 9'(SCR_H));
  assign bg_c = 19'(posY) * 19'(SCR_W) + 19'(posX);

  // Signed rectangle test and sprite address per layer (no unsigned wrap).
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      rx[i] = $signed({1'b0, posX}) - $signed({1'b0, cx[i]});
      ry[i] = $signed({2'b0, posY}) - $signed({2'b0, cy[i]});
      prod[i] = 22'(ry[i]) * 22'(cw[i]) + 22'(rx[i]);
      hit_c[i] = on_scr && layer_en[i] && (cw[i] != 10'd0)
              && !rx[i][10] && (rx[i] < $signed({1'b0, cw[i]}))
              && !ry[i][10] && (ry[i] < $signed({2'b0, ch[i]}));
    end
  end

  // S1 and S2: addresses out to the ROMs, control delayed to meet the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      bg_addr  <= '0;
      hit1     <= '0;
      gs1      <= '0;
      v1       <= 1'b0;
      hit2     <= '0;
      gs2      <= '0;
      v2       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++)
        rom_addr[i*AW +: AW] <= prod[i][AW-1:0];
      bg_addr <= bg_c;
      hit1    <= hit_c;
      gs1     <= game_state;
      v1      <= pix_valid;
      hit2    <= hit1;
      gs2     <= gs1;
      v2      <= v1;
    end
  end

  // Priority pick: lowest index wins unless the reward layer is promoted.
  always_comb begin
    pick = bg_data;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit2[i] && rom_data[i*16 +: 16] != KEY_COLOR)
        pick = rom_data[i*16 +: 16];
    end
    if (gs2 == GS_SUCCESS && hit2[NUM_LAYERS-1]
        && rom_data[(NUM_LAYERS-1)*16 +: 16] != KEY_COLOR)
      pick = rom_data[(NUM_LAYERS-1)*16 +: 16];
    mix_c = pick;
    case (gs2)
      GS_INITIAL: mix_c = INIT_COLOR;
      GS_OVER: begin
        if (pick != KEY_COLOR)
          mix_c = {1'b0, pick[15:12], 1'b0, pick[10:6], 1'b0, pick[4:1]};
      end
      default: mix_c = pick;
    endcase
  end

  // S3: output register; bubbles leave the last colour in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ocolor       <= 16'h0000;
      ocolor_valid <= 1'b0;
    end else begin
      ocolor_valid <= v2;
      if (v2)
        ocolor <= mix_c;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed and random pixels checked against a
// rectangle/priority reference model with a 3-deep expectation queue.
module tb_layer_compositor;

  localparam int N = 4;
  localparam int AW = 12;
  localparam logic [15:0] KEY = 16'hFFFF;
  localparam logic [15:0] INIT = 16'hF0FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_valid = 1'b0;
  logic [9:0] posX = '0;
  logic [8:0] posY = '0;
  logic [1:0] game_state = 2'b01;
  logic [N-1:0] layer_en = '1;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [9:0] cfg_x = '0;
  logic [8:0] cfg_y = '0;
  logic [9:0] cfg_w = '0;
  logic [8:0] cfg_h = '0;
  logic [N*AW-1:0] rom_addr;
  logic [N*16-1:0] rom_data = '0;
  logic [18:0] bg_addr;
  logic [15:0] bg_data = '0;
  logic [15:0] ocolor;
  logic ocolor_valid;

  int mode = 0;
  logic [15:0] cdata [N];
  logic [15:0] bg_const = 16'h1234;
  int mx [N];
  int my [N];
  int mw [N];
  int mh [N];
  int passed = 0;
  int total = 0;
  logic [15:0] last = '0;

  typedef struct {
    logic v;
    logic [15:0] c;
    bit has;
    logic [15:0] lit;
    int id;
  } ent_t;
  ent_t q [$];

  layer_compositor dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid),
    .posX(posX), .posY(posY), .game_state(game_state),
    .layer_en(layer_en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .bg_addr(bg_addr), .bg_data(bg_data),
    .ocolor(ocolor), .ocolor_valid(ocolor_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mix32(input logic [31:0] s);
    logic [31:0] x;
    x = s * 32'h9E3779B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EBCA6B;
    x = x ^ (x >> 13);
    return x;
  endfunction

  function automatic logic [15:0] ldata(input int i, input int a);
    logic [31:0] h;
    if (mode == 0) return 16'(a);
    if (mode == 1) return cdata[i];
    h = mix32(32'(i) * 32'd8192 + 32'(a) + 32'd1);
    if (h[18:16] == 3'd0) return KEY;
    return h[15:0];
  endfunction

  function automatic logic [15:0] bgfn(input int a);
    logic [31:0] h;
    if (mode != 2) return bg_const;
    h = mix32(32'(a) ^ 32'h5A5A0000);
    if (h[20:17] == 4'd0) return KEY;
    return h[15:0];
  endfunction

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      rom_data[i*16 +: 16] <= ldata(i, int'(rom_addr[i*AW +: AW]));
    bg_data <= bgfn(int'(bg_addr));
  end

  function automatic logic [15:0] expect_color(input int px, input int py,
                                               input logic [1:0] gs,
                                               input logic [N-1:0] en);
    logic [15:0] sel;
    logic [15:0] d;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    bit found;
    int i;
    int rxi;
    int ryi;
    if (gs == 2'd0) return INIT;
    found = 0;
    sel = '0;
    for (int k = 0; k < N; k++) begin
      i = (gs == 2'd3) ? ((k == 0) ? N - 1 : k - 1) : k;
      rxi = px - mx[i];
      ryi = py - my[i];
      if (en[i] && mw[i] != 0 && rxi >= 0 && rxi < mw[i]
          && ryi >= 0 && ryi < mh[i]) begin
        d = ldata(i, (ryi * mw[i] + rxi) % 4096);
        if (!found && d != KEY) begin
          sel = d;
          found = 1;
        end
      end
    end
    if (!found) sel = bgfn(py * 640 + px);
    if (gs == 2'd2 && sel != KEY) begin
      r = sel[15:11] >> 1;
      g = sel[10:5] >> 1;
      b = sel[4:0] >> 1;
      sel = {r, g, b};
    end
    return sel;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle(input bit has, input logic [15:0] lit, input int id);
    ent_t e;
    ent_t o;
    e.v = pix_valid;
    e.c = pix_valid ? expect_color(int'(posX), int'(posY), game_state,
                                   layer_en) : 16'h0;
    e.has = has;
    e.lit = lit;
    e.id = id;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 3) begin
      o = q.pop_front();
      chk("valid", 32'(ocolor_valid), 32'(o.v));
      if (o.v) begin
        chk("color", 32'(ocolor), 32'(o.c));
        last = o.c;
        if (o.has) chk($sformatf("lit%0d", o.id), 32'(ocolor), 32'(o.lit));
      end else begin
        chk("hold", 32'(ocolor), 32'(last));
      end
    end else begin
      chk("fill_valid", 32'(ocolor_valid), 32'd0);
      chk("fill_color", 32'(ocolor), 32'(last));
    end
    if (cfg_we) begin
      mx[cfg_sel] = int'(cfg_x);
      my[cfg_sel] = int'(cfg_y);
      mw[cfg_sel] = int'(cfg_w);
      mh[cfg_sel] = int'(cfg_h);
    end
  endtask

  task automatic px(input int x, input int y, input bit has,
                    input logic [15:0] lit, input int id);
    pix_valid = 1'b1;
    posX = 10'(x);
    posY = 9'(y);
    cycle(has, lit, id);
    pix_valid = 1'b0;
  endtask

  task automatic flush();
    pix_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle(0, 16'h0, 0);
  endtask

  task automatic cfg(input int sel, input int x, input int y,
                     input int w, input int h);
    pix_valid = 1'b0;
    cfg_we = 1'b1;
    cfg_sel = 2'(sel);
    cfg_x = 10'(x);
    cfg_y = 9'(y);
    cfg_w = 10'(w);
    cfg_h = 9'(h);
    cycle(0, 16'h0, 0);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    cfg_we = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_valid", 32'(ocolor_valid), 32'd0);
    chk("rst_color", 32'(ocolor), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    last = '0;
    for (int i = 0; i < N; i++) begin
      mx[i] = 0;
      my[i] = 0;
      mw[i] = 0;
      mh[i] = 0;
    end
  endtask

  initial begin
    cdata[0] = KEY;
    cdata[1] = 16'h07E0;
    cdata[2] = 16'h0ABC;
    cdata[3] = 16'h001F;
    @(posedge clk);
    #1;
    do_reset();

    // Single layer, ROM returns its address.
    mode = 0;
    game_state = 2'b01;
    cfg(0, 100, 50, 10, 4);
    px(109, 53, 1, 16'h0027, 1);
    chk("rom_addr0", 32'(rom_addr[AW-1:0]), 32'd39);
    chk("bg_addr", 32'(bg_addr), 32'd34029);
    px(110, 53, 1, 16'h1234, 2);
    px(100, 50, 1, 16'h0000, 3);
    px(99, 50, 1, 16'h1234, 4);
    flush();

    // Priority and transparency.
    mode = 1;
    cfg(0, 195, 195, 10, 10);
    cfg(1, 198, 198, 5, 5);
    cfg(3, 200, 200, 1, 1);
    px(200, 200, 1, 16'h07E0, 5);
    px(196, 196, 1, 16'h1234, 6);
    flush();
    cdata[0] = 16'hF800;
    px(200, 200, 1, 16'hF800, 7);
    game_state = 2'b11;
    px(200, 200, 1, 16'h001F, 8);
    game_state = 2'b00;
    px(200, 200, 1, INIT, 9);
    game_state = 2'b01;
    flush();

    // Clipping at the right screen edge.
    layer_en = 4'b0100;
    cfg(2, 600, 10, 52, 1);
    for (int x = 0; x < 12; x++) px(x, 10, 1, 16'h1234, 10 + x);
    px(639, 10, 1, 16'h0ABC, 30);
    px(600, 10, 1, 16'h0ABC, 31);
    px(599, 10, 1, 16'h1234, 32);
    flush();

    // OVER dimming; the key colour is never dimmed.
    cdata[2] = 16'hFFDF;
    game_state = 2'b10;
    px(639, 10, 1, 16'h7BEF, 33);
    px(5, 10, 1, 16'h090A, 34);
    flush();
    bg_const = KEY;
    cdata[2] = KEY;
    px(639, 10, 1, KEY, 35);
    px(5, 10, 1, KEY, 36);
    flush();
    bg_const = 16'h1234;
    game_state = 2'b01;
    layer_en = '1;

    // Moving a layer while a pixel sits in S2.
    cdata[0] = 16'h0F0F;
    cfg(0, 300, 300, 5, 5);
    px(302, 302, 1, 16'h0F0F, 37);
    pix_valid = 1'b1;
    cfg_we = 1'b1;
    cfg_sel = 2'd0;
    cfg_x = 10'd400;
    cfg_y = 9'd300;
    cfg_w = 10'd5;
    cfg_h = 9'd5;
    cycle(1, 16'h0F0F, 38);
    cfg_we = 1'b0;
    px(302, 302, 1, 16'h1234, 39);
    px(402, 302, 1, 16'h0F0F, 40);
    layer_en = 4'b1110;
    px(402, 302, 1, 16'h1234, 41);
    layer_en = '1;
    flush();

    // Random traffic, with one reset in the middle of the stream.
    mode = 2;
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      pix_valid = ($urandom_range(0, 4) != 0);
      posX = 10'($urandom_range(0, 639));
      posY = 9'($urandom_range(0, 479));
      if ($urandom_range(0, 49) == 0) game_state = 2'($urandom);
      if ($urandom_range(0, 99) == 0) layer_en = 4'($urandom);
      cfg_we = ($urandom_range(0, 29) == 0) || (n == 701) || (n == 702);
      cfg_sel = 2'($urandom);
      cfg_x = 10'($urandom_range(0, 639));
      cfg_y = 9'($urandom_range(0, 479));
      cfg_w = ($urandom_range(0, 7) == 0) ? 10'd0
              : 10'($urandom_range(1, 300));
      cfg_h = 9'($urandom_range(1, 300));
      cycle(0, 16'h0, 0);
      cfg_we = 1'b0;
    end
    flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
